// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared ROB/reservation-station constants, types and tag helpers
package reorder_buffer_pkg;
    localparam int DEPTH = 16;
    localparam int TAG_W = 6;
    localparam int DATA_W = 32;
    localparam int REG_W = 5;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [TAG_W-1:0] INVALID_TAG = 6'b010000;

    typedef enum logic [2:0] {
        ADD_OP,
        SUB_OP,
        MUL_OP,
        DIV_OP,
        LW_OP,
        SW_OP,
        BNE_OP,
        LI_OP
    } op_e;

    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0] reg_t;
    typedef logic [PTR_W-1:0] ptr_t;

    function automatic logic tag_in_range(input tag_t t);
        return t < TAG_W'(DEPTH);
    endfunction

    function automatic ptr_t tag_slot(input tag_t t);
        return t[PTR_W-1:0];
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, CDB, operand lookup and commit signals of the ROB
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic  flush;
    logic  alloc_valid;
    reg_t  alloc_dest;
    logic  alloc_has_dest;
    logic  alloc_ready;
    tag_t  alloc_tag;
    logic  cdb1_valid;
    tag_t  cdb1_tag;
    data_t cdb1_data;
    logic  cdb2_valid;
    tag_t  cdb2_tag;
    data_t cdb2_data;
    tag_t  index;
    logic  ready;
    data_t value;
    logic  commit_valid;
    tag_t  commit_tag;
    reg_t  commit_reg;
    logic  commit_we;
    data_t commit_data;
    logic  empty;

    modport master (
        output flush, alloc_valid, alloc_dest, alloc_has_dest,
        output cdb1_valid, cdb1_tag, cdb1_data, cdb2_valid, cdb2_tag, cdb2_data, index,
        input  alloc_ready, alloc_tag, ready, value,
        input  commit_valid, commit_tag, commit_reg, commit_we, commit_data, empty
    );

    modport slave (
        input  flush, alloc_valid, alloc_dest, alloc_has_dest,
        input  cdb1_valid, cdb1_tag, cdb1_data, cdb2_valid, cdb2_tag, cdb2_data, index,
        output alloc_ready, alloc_tag, ready, value,
        output commit_valid, commit_tag, commit_reg, commit_we, commit_data, empty
    );
endinterface

// File: rtl/reorder_buffer_lookup_mux.sv
// rob_lookup_mux: combinational operand read port with same-cycle CDB bypass
module rob_lookup_mux
    import reorder_buffer_pkg::*;
(
    input  tag_t             index,
    input  logic [DEPTH-1:0] busy,
    input  logic [DEPTH-1:0] done,
    input  data_t            data [DEPTH],
    input  logic             cdb1_valid,
    input  tag_t             cdb1_tag,
    input  data_t            cdb1_data,
    input  logic             cdb2_valid,
    input  tag_t             cdb2_tag,
    input  data_t            cdb2_data,
    output logic             ready,
    output data_t            value
);
    ptr_t slot;
    logic live;

    assign slot = tag_slot(index);
    assign live = tag_in_range(index) && busy[slot];

    // stored result wins; otherwise bypass a broadcast hitting a live entry, cdb1 first
    always_comb begin
        ready = 1'b0;
        value = '0;
        if (live && done[slot]) begin
            ready = 1'b1;
            value = data[slot];
        end else if (live && cdb1_valid && cdb1_tag == index) begin
            ready = 1'b1;
            value = cdb1_data;
        end else if (live && cdb2_valid && cdb2_tag == index) begin
            ready = 1'b1;
            value = cdb2_data;
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: 16-entry circular ROB with dual CDB capture and in-order retirement
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input logic       clock,
    input logic       reset,
    reorder_buffer_if.slave rob
);
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] has_dest;
    reg_t             dest [DEPTH];
    data_t            result [DEPTH];
    ptr_t             head;
    ptr_t             tail;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             do_alloc;
    logic             do_commit;
    logic             hit1;
    logic             hit2;
    ptr_t             slot1;
    ptr_t             slot2;

    assign full = count == CNT_W'(DEPTH);
    assign rob.alloc_ready = !full;
    assign rob.alloc_tag = TAG_W'(tail);
    assign rob.empty = count == '0;
    assign do_alloc = rob.alloc_valid && !full;
    assign do_commit = busy[head] && done[head];
    assign slot1 = tag_slot(rob.cdb1_tag);
    assign slot2 = tag_slot(rob.cdb2_tag);
    assign hit1 = rob.cdb1_valid && tag_in_range(rob.cdb1_tag) && busy[slot1] && !done[slot1];
    assign hit2 = rob.cdb2_valid && tag_in_range(rob.cdb2_tag) && busy[slot2] && !done[slot2];

    // entry status, pointers and registered commit port; flush overrides every other action
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy             <= '0;
            done             <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            rob.commit_valid <= 1'b0;
            rob.commit_we    <= 1'b0;
            rob.commit_tag   <= INVALID_TAG;
            rob.commit_reg   <= '0;
            rob.commit_data  <= '0;
        end else if (rob.flush) begin
            busy             <= '0;
            done             <= '0;
            head             <= '0;
            tail             <= '0;
            count            <= '0;
            rob.commit_valid <= 1'b0;
            rob.commit_we    <= 1'b0;
        end else begin
            if (hit2) done[slot2] <= 1'b1;
            if (hit1) done[slot1] <= 1'b1;
            rob.commit_valid <= do_commit;
            rob.commit_we    <= do_commit && has_dest[head];
            if (do_commit) begin
                busy[head]      <= 1'b0;
                done[head]      <= 1'b0;
                head            <= head + 1'b1;
                rob.commit_tag  <= TAG_W'(head);
                rob.commit_reg  <= dest[head];
                rob.commit_data <= result[head];
            end
            if (do_alloc) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + 1'b1;
            end
            count <= count + CNT_W'(do_alloc) - CNT_W'(do_commit);
        end
    end

    // payload storage; busy/done gate every read so it needs no reset
    always_ff @(posedge clock) begin
        if (do_alloc) begin
            dest[tail]     <= rob.alloc_dest;
            has_dest[tail] <= rob.alloc_has_dest;
        end
        if (hit2) result[slot2] <= rob.cdb2_data;
        if (hit1) result[slot1] <= rob.cdb1_data;
    end

    rob_lookup_mux u_lookup (
        .index      (rob.index),
        .busy       (busy),
        .done       (done),
        .data       (result),
        .cdb1_valid (rob.cdb1_valid),
        .cdb1_tag   (rob.cdb1_tag),
        .cdb1_data  (rob.cdb1_data),
        .cdb2_valid (rob.cdb2_valid),
        .cdb2_tag   (rob.cdb2_tag),
        .cdb2_data  (rob.cdb2_data),
        .ready      (rob.ready),
        .value      (rob.value)
    );
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus randomized traffic against a queue-level ROB model
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    reorder_buffer_if rif();

    reorder_buffer dut (
        .clock (clock),
        .reset (reset),
        .rob   (rif)
    );

    always #5 clock = ~clock;

    bit          m_busy [DEPTH];
    bit          m_done [DEPTH];
    bit          m_hd   [DEPTH];
    logic [4:0]  m_dest [DEPTH];
    logic [31:0] m_data [DEPTH];
    int          m_head, m_tail, m_count;
    logic        e_cv, e_cwe;
    logic [5:0]  e_ctag;
    logic [4:0]  e_creg;
    logic [31:0] e_cdata;

    task automatic model_reset();
        foreach (m_busy[i]) begin
            m_busy[i] = 0;
            m_done[i] = 0;
        end
        m_head = 0; m_tail = 0; m_count = 0;
        e_cv = 0; e_cwe = 0; e_ctag = 6'd16; e_creg = 0; e_cdata = 0;
    endtask

    task automatic idle();
        rif.flush = 0; rif.alloc_valid = 0; rif.alloc_dest = 0; rif.alloc_has_dest = 0;
        rif.cdb1_valid = 0; rif.cdb1_tag = 0; rif.cdb1_data = 0;
        rif.cdb2_valid = 0; rif.cdb2_tag = 0; rif.cdb2_data = 0;
        rif.index = 0;
    endtask

    // advance one clock edge and apply the same edge to the model using the inputs driven before it
    task automatic step();
        bit c, a, h1, h2;
        int t1, t2;
        @(posedge clock);
        if (rif.flush) begin
            foreach (m_busy[i]) begin
                m_busy[i] = 0;
                m_done[i] = 0;
            end
            m_head = 0; m_tail = 0; m_count = 0; e_cv = 0; e_cwe = 0;
        end else begin
            c = m_busy[m_head] && m_done[m_head];
            a = rif.alloc_valid && m_count < DEPTH;
            t1 = int'(rif.cdb1_tag);
            t2 = int'(rif.cdb2_tag);
            h1 = rif.cdb1_valid && t1 < DEPTH && m_busy[t1 % DEPTH] && !m_done[t1 % DEPTH];
            h2 = rif.cdb2_valid && t2 < DEPTH && m_busy[t2 % DEPTH] && !m_done[t2 % DEPTH];
            if (h2) begin m_done[t2] = 1; m_data[t2] = rif.cdb2_data; end
            if (h1) begin m_done[t1] = 1; m_data[t1] = rif.cdb1_data; end
            e_cv = c;
            e_cwe = c && m_hd[m_head];
            if (c) begin
                e_ctag = 6'(m_head); e_creg = m_dest[m_head]; e_cdata = m_data[m_head];
                m_busy[m_head] = 0; m_done[m_head] = 0;
                m_head = (m_head + 1) % DEPTH; m_count--;
            end
            if (a) begin
                m_busy[m_tail] = 1; m_done[m_tail] = 0;
                m_dest[m_tail] = rif.alloc_dest; m_hd[m_tail] = rif.alloc_has_dest;
                m_tail = (m_tail + 1) % DEPTH; m_count++;
            end
        end
        #1;
    endtask

    function automatic logic [32:0] m_look(input int idx);
        if (idx >= DEPTH) return '0;
        if (m_busy[idx] && m_done[idx]) return {1'b1, m_data[idx]};
        if (m_busy[idx] && rif.cdb1_valid && int'(rif.cdb1_tag) == idx) return {1'b1, rif.cdb1_data};
        if (m_busy[idx] && rif.cdb2_valid && int'(rif.cdb2_tag) == idx) return {1'b1, rif.cdb2_data};
        return '0;
    endfunction

    task automatic do_flush();
        rif.flush = 1;
        step();
        rif.flush = 0;
    endtask

    task automatic test_reset();
        idle();
        #12;
        checks++; if (rif.empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", rif.empty); end
        checks++; if (rif.alloc_ready !== 1'b1) begin failures++; $display("FAIL reset_alloc_ready got=%0b exp=1", rif.alloc_ready); end
        checks++; if (rif.alloc_tag !== 6'd0) begin failures++; $display("FAIL reset_alloc_tag got=%0d exp=0", rif.alloc_tag); end
        checks++; if (rif.commit_valid !== 1'b0 || rif.commit_we !== 1'b0) begin failures++; $display("FAIL reset_commit got=%0b/%0b exp=0/0", rif.commit_valid, rif.commit_we); end
        checks++; if (rif.commit_tag !== INVALID_TAG || rif.commit_reg !== 5'd0 || rif.commit_data !== 32'd0) begin failures++; $display("FAIL reset_commit_fields got=%0d/%0d/%0h exp=16/0/0", rif.commit_tag, rif.commit_reg, rif.commit_data); end
        reset = 1;
        model_reset();
    endtask

    task automatic test_basic();
        rif.alloc_valid = 1; rif.alloc_dest = 5'd3; rif.alloc_has_dest = 1;
        #1;
        checks++; if (rif.alloc_tag !== 6'd0) begin failures++; $display("FAIL basic_alloc_tag got=%0d exp=0", rif.alloc_tag); end
        step();
        idle();
        checks++; if (rif.empty !== 1'b0) begin failures++; $display("FAIL basic_not_empty got=%0b exp=0", rif.empty); end
        rif.cdb1_valid = 1; rif.cdb1_tag = 6'd0; rif.cdb1_data = 32'h1234;
        step();
        idle();
        checks++; if (rif.commit_valid !== 1'b0) begin failures++; $display("FAIL basic_early_commit got=%0b exp=0", rif.commit_valid); end
        step();
        checks++; if (rif.commit_valid !== 1'b1 || rif.commit_we !== 1'b1) begin failures++; $display("FAIL basic_commit got=%0b/%0b exp=1/1", rif.commit_valid, rif.commit_we); end
        checks++; if (rif.commit_reg !== 5'd3 || rif.commit_data !== 32'h1234 || rif.commit_tag !== 6'd0) begin failures++; $display("FAIL basic_commit_fields got=%0d/%0h/%0d exp=3/1234/0", rif.commit_reg, rif.commit_data, rif.commit_tag); end
        checks++; if (rif.empty !== 1'b1) begin failures++; $display("FAIL basic_empty_after got=%0b exp=1", rif.empty); end
        step();
        checks++; if (rif.commit_valid !== 1'b0) begin failures++; $display("FAIL basic_commit_pulse got=%0b exp=0", rif.commit_valid); end
    endtask

    task automatic test_in_order();
        logic [4:0] dests [3] = '{5'd1, 5'd2, 5'd4};
        do_flush();
        for (int i = 0; i < 3; i++) begin
            rif.alloc_valid = 1; rif.alloc_dest = dests[i]; rif.alloc_has_dest = 1;
            #1;
            checks++; if (rif.alloc_tag !== 6'(i)) begin failures++; $display("FAIL order_alloc_tag got=%0d exp=%0d", rif.alloc_tag, i); end
            step();
        end
        idle();
        for (int i = 2; i >= 0; i--) begin
            rif.cdb1_valid = 1; rif.cdb1_tag = 6'(i); rif.cdb1_data = 32'(100 + i);
            step();
            checks++; if (rif.commit_valid !== 1'b0) begin failures++; $display("FAIL order_premature_commit got=%0b exp=0 at tag %0d", rif.commit_valid, i); end
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 6'(i) || rif.commit_reg !== dests[i] || rif.commit_data !== 32'(100 + i)) begin
                failures++; $display("FAIL order_commit got=%0b/%0d/%0d/%0d exp=1/%0d/%0d/%0d", rif.commit_valid, rif.commit_tag, rif.commit_reg, rif.commit_data, i, dests[i], 100 + i);
            end
        end
        step();
        checks++; if (rif.commit_valid !== 1'b0 || rif.empty !== 1'b1) begin failures++; $display("FAIL order_drained got=%0b/%0b exp=0/1", rif.commit_valid, rif.empty); end
    endtask

    task automatic test_full_wrap();
        do_flush();
        rif.alloc_valid = 1; rif.alloc_has_dest = 1;
        for (int i = 0; i < DEPTH; i++) begin
            rif.alloc_dest = 5'(i);
            step();
        end
        checks++; if (rif.alloc_ready !== 1'b0 || rif.alloc_tag !== 6'd0) begin failures++; $display("FAIL full_ready got=%0b/%0d exp=0/0", rif.alloc_ready, rif.alloc_tag); end
        step();
        checks++; if (rif.alloc_ready !== 1'b0 || rif.alloc_tag !== 6'd0 || rif.commit_valid !== 1'b0) begin failures++; $display("FAIL full_17th_ignored got=%0b/%0d/%0b exp=0/0/0", rif.alloc_ready, rif.alloc_tag, rif.commit_valid); end
        rif.cdb1_valid = 1; rif.cdb1_tag = 6'd0; rif.cdb1_data = 32'hAA;
        step();
        rif.cdb1_valid = 0;
        checks++; if (rif.alloc_ready !== 1'b0) begin failures++; $display("FAIL full_after_capture got=%0b exp=0", rif.alloc_ready); end
        step();
        checks++; if (rif.commit_valid !== 1'b1 || rif.commit_tag !== 6'd0 || rif.commit_data !== 32'hAA) begin failures++; $display("FAIL wrap_commit got=%0b/%0d/%0h exp=1/0/aa", rif.commit_valid, rif.commit_tag, rif.commit_data); end
        checks++; if (rif.alloc_ready !== 1'b1 || rif.alloc_tag !== 6'd0) begin failures++; $display("FAIL wrap_free got=%0b/%0d exp=1/0", rif.alloc_ready, rif.alloc_tag); end
        step();
        checks++; if (rif.alloc_ready !== 1'b0 || rif.alloc_tag !== 6'd1 || m_tail != 1) begin failures++; $display("FAIL wrap_realloc got=%0b/%0d exp=0/1", rif.alloc_ready, rif.alloc_tag); end
        idle();
    endtask

    task automatic test_lookup_bypass();
        rif.index = 6'd5; rif.cdb2_valid = 1; rif.cdb2_tag = 6'd5; rif.cdb2_data = 32'd77;
        #1;
        checks++; if (rif.ready !== 1'b1 || rif.value !== 32'd77) begin failures++; $display("FAIL bypass_cdb2 got=%0b/%0d exp=1/77", rif.ready, rif.value); end
        rif.index = INVALID_TAG;
        #1;
        checks++; if (rif.ready !== 1'b0) begin failures++; $display("FAIL lookup_invalid got=%0b exp=0", rif.ready); end
        rif.index = 6'd5;
        step();
        idle();
        rif.index = 6'd5;
        #1;
        checks++; if (rif.ready !== 1'b1 || rif.value !== 32'd77) begin failures++; $display("FAIL lookup_stored got=%0b/%0d exp=1/77", rif.ready, rif.value); end
        rif.index = 6'd7; rif.cdb1_valid = 1; rif.cdb1_tag = 6'd7; rif.cdb1_data = 32'd1;
        rif.cdb2_valid = 1; rif.cdb2_tag = 6'd7; rif.cdb2_data = 32'd2;
        #1;
        checks++; if (rif.ready !== 1'b1 || rif.value !== 32'd1) begin failures++; $display("FAIL bypass_priority got=%0b/%0d exp=1/1", rif.ready, rif.value); end
        idle();
        rif.index = 6'd6;
        #1;
        checks++; if (rif.ready !== 1'b0 || rif.value !== 32'd0) begin failures++; $display("FAIL lookup_pending got=%0b/%0d exp=0/0", rif.ready, rif.value); end
    endtask

    task automatic test_cdb_priority();
        idle();
        do_flush();
        rif.alloc_valid = 1;
        for (int i = 0; i < 5; i++) step();
        idle();
        rif.cdb1_valid = 1; rif.cdb1_tag = 6'd4; rif.cdb1_data = 32'd10;
        rif.cdb2_valid = 1; rif.cdb2_tag = 6'd4; rif.cdb2_data = 32'd20;
        step();
        idle();
        rif.index = 6'd4;
        #1;
        checks++; if (rif.ready !== 1'b1 || rif.value !== 32'd10) begin failures++; $display("FAIL cdb_port1_wins got=%0b/%0d exp=1/10", rif.ready, rif.value); end
        rif.cdb1_valid = 1; rif.cdb1_tag = 6'd9; rif.cdb1_data = 32'd99;
        step();
        idle();
        rif.index = 6'd9;
        #1;
        checks++; if (rif.ready !== 1'b0 || rif.alloc_tag !== 6'd5 || rif.empty !== 1'b0) begin failures++; $display("FAIL cdb_free_dropped got=%0b/%0d/%0b exp=0/5/0", rif.ready, rif.alloc_tag, rif.empty); end
    endtask

    task automatic test_flush();
        rif.cdb1_valid = 1; rif.cdb1_tag = 6'd0; rif.cdb1_data = 32'd5;
        step();
        rif.flush = 1; rif.alloc_valid = 1; rif.cdb1_tag = 6'd1; rif.cdb1_data = 32'd6;
        step();
        idle();
        checks++; if (rif.commit_valid !== 1'b0 || rif.empty !== 1'b1 || rif.alloc_tag !== 6'd0) begin failures++; $display("FAIL flush_state got=%0b/%0b/%0d exp=0/1/0", rif.commit_valid, rif.empty, rif.alloc_tag); end
        step();
        checks++; if (rif.commit_valid !== 1'b0 || rif.empty !== 1'b1) begin failures++; $display("FAIL flush_no_commit got=%0b/%0b exp=0/1", rif.commit_valid, rif.empty); end
    endtask

    task automatic test_async_reset();
        rif.alloc_valid = 1; rif.alloc_dest = 5'd7; rif.alloc_has_dest = 1;
        step();
        idle();
        rif.cdb1_valid = 1; rif.cdb1_tag = 6'd0; rif.cdb1_data = 32'h55;
        step();
        idle();
        step();
        checks++; if (rif.commit_valid !== 1'b1 || rif.commit_reg !== 5'd7) begin failures++; $display("FAIL areset_precommit got=%0b/%0d exp=1/7", rif.commit_valid, rif.commit_reg); end
        #2;
        reset = 0;
        #1;
        checks++; if (rif.commit_valid !== 1'b0 || rif.commit_we !== 1'b0 || rif.commit_tag !== INVALID_TAG) begin failures++; $display("FAIL areset_commit got=%0b/%0b/%0d exp=0/0/16", rif.commit_valid, rif.commit_we, rif.commit_tag); end
        checks++; if (rif.empty !== 1'b1 || rif.alloc_ready !== 1'b1 || rif.alloc_tag !== 6'd0) begin failures++; $display("FAIL areset_status got=%0b/%0b/%0d exp=1/1/0", rif.empty, rif.alloc_ready, rif.alloc_tag); end
        model_reset();
        #3;
        reset = 1;
    endtask

    task automatic test_random();
        logic [32:0] exp_look;
        for (int n = 0; n < 600; n++) begin
            rif.flush = ($urandom_range(0, 39) == 0);
            rif.alloc_valid = $urandom_range(0, 1);
            rif.alloc_dest = 5'($urandom);
            rif.alloc_has_dest = $urandom_range(0, 1);
            rif.cdb1_valid = $urandom_range(0, 1);
            rif.cdb1_tag = 6'($urandom_range(0, 17));
            rif.cdb1_data = $urandom;
            rif.cdb2_valid = $urandom_range(0, 1);
            rif.cdb2_tag = 6'($urandom_range(0, 17));
            rif.cdb2_data = $urandom;
            rif.index = 6'($urandom_range(0, 17));
            #1;
            exp_look = m_look(int'(rif.index));
            checks++; if ({rif.ready, rif.value} !== exp_look) begin failures++; $display("FAIL rand_lookup idx=%0d got=%0b/%0h exp=%0b/%0h", rif.index, rif.ready, rif.value, exp_look[32], exp_look[31:0]); end
            step();
            checks++; if (rif.commit_valid !== e_cv || rif.commit_we !== e_cwe) begin failures++; $display("FAIL rand_commit got=%0b/%0b exp=%0b/%0b", rif.commit_valid, rif.commit_we, e_cv, e_cwe); end
            if (e_cv) begin
                checks++; if (rif.commit_tag !== e_ctag || rif.commit_reg !== e_creg || rif.commit_data !== e_cdata) begin failures++; $display("FAIL rand_commit_fields got=%0d/%0d/%0h exp=%0d/%0d/%0h", rif.commit_tag, rif.commit_reg, rif.commit_data, e_ctag, e_creg, e_cdata); end
            end
            checks++; if (rif.alloc_ready !== (m_count < DEPTH) || rif.alloc_tag !== 6'(m_tail) || rif.empty !== (m_count == 0)) begin
                failures++; $display("FAIL rand_status got=%0b/%0d/%0b exp=%0b/%0d/%0b", rif.alloc_ready, rif.alloc_tag, rif.empty, m_count < DEPTH, m_tail, m_count == 0);
            end
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_in_order();
        test_full_wrap();
        test_lookup_bypass();
        test_cdb_priority();
        test_flush();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
16-entry circular reorder buffer downstream of the add/mul reservation stations and the load/store unit. It allocates ROB tags at issue and captures results from both CDB broadcast ports. It answers the reservation stations' operand lookup (index/ready/value) and retires one completed entry per cycle, in program order, to the register file.

Parameters:
DEPTH, 16, number of entries; tags 0..DEPTH-1 are valid.
TAG_W, 6, width of tag buses; must match reservation-station robNum width.
INVALID_TAG, 6'b010000, tag meaning "no producer / value present".
DATA_W, 32, result width.

Ports:
clock  in  1  single clock, all state updates on posedge
reset  in  1  asynchronous, active-low; low clears all state immediately
flush  in  1  synchronous discard of all entries (branch mispredict)
alloc_valid  in  1  issue requests a new entry this cycle
alloc_dest  in  5  architectural destination register
alloc_has_dest  in  1  0 for sw/bne (no register write on commit)
alloc_ready  out  1  entry available (combinational: !full)
alloc_tag  out  6  tag granted this cycle (= tail pointer, combinational)
cdb1_valid / cdb1_tag / cdb1_data  in  1/6/32  CDB port 1
cdb2_valid / cdb2_tag / cdb2_data  in  1/6/32  CDB port 2
index  in  6  operand lookup tag from a reservation station
ready  out  1  looked-up entry has its value (combinational)
value  out  32  looked-up value (combinational)
commit_valid  out  1  registered; one-cycle pulse per retired entry
commit_tag  out  6  tag of retired entry
commit_reg  out  5  destination register
commit_we  out  1  commit_valid & has_dest
commit_data  out  32  retired result
empty  out  1  count == 0

Behaviour:
- Per-entry state: busy, done, has_dest, dest[4:0], data[31:0]. Pointers: head, tail (4-bit, wrap 15->0). count (5-bit, 0..16).
- Reset (reset=0, asynchronous): all busy/done cleared, head=tail=0, count=0. Outputs: commit_valid=0, commit_we=0, commit_tag=INVALID_TAG, commit_reg=0, commit_data=0. Combinational outputs then read alloc_ready=1, alloc_tag=0, empty=1. Reset mid-operation discards every entry, including in-flight CDB writes.
- Allocation: accepted at posedge when alloc_valid & alloc_ready. Entry[tail] gets busy=1, done=0, dest, has_dest; tail++, count++. alloc_valid while full is ignored; no state change.
- CDB capture: for each port p with cdbp_valid & cdbp_tag<DEPTH & entry busy & !done, set done=1 and data=cdbp_data. Tags >= DEPTH are ignored. If both ports carry the same tag, port 1 wins. A CDB write to a non-busy entry is dropped.
- Lookup (combinational): if index>=DEPTH then ready=0. Otherwise ready=1 when the entry is busy & done, with value=data. Same-cycle bypass: if cdb1 (or else cdb2) hits index with the entry busy, then ready=1 and value=that CDB data. Otherwise ready=0 and value=0.
- Commit: at posedge, if entry[head] is busy & done, register its fields to the commit outputs, clear busy/done, head++, count--, and drive commit_valid=1 for exactly that cycle; else commit_valid=0. Latency: a CDB write captured at edge N is committed at edge N+1 at the earliest. A bypassed CDB value is never committed in the same edge.
- Simultaneous alloc+commit: both act; count unchanged. When full, alloc_ready=0 for that cycle even if a commit occurs (no same-cycle reuse).
- Wrap-around: tags are reused after 16 allocations; head/tail compare uses count, so full vs. empty is never ambiguous.
- flush=1 at posedge: clears all entries, head=tail=0, count=0, commit_valid=0. Flush overrides alloc, CDB and commit in that cycle.

Decomposition:
- Shared package (alongside the operator codes): INVALID_TAG, DEPTH, TAG_W, DATA_W, and the op code constants (addOp..liOp) used by all stations.
- One natural sub-module, rob_lookup_mux: a combinational index/CDB bypass read port. It is instantiated once here and can be reused for a second lookup port later.

Test Plan:
- Reset then alloc dest=3 -> alloc_tag=0, count=1. cdb1 tag=0 data=0x1234 -> next edge commit_valid=1, commit_reg=3, commit_we=1, commit_data=0x1234; empty=1 afterwards.
- Alloc tags 0,1,2; CDB completes 2 then 1 then 0 -> commits strictly in order 0,1,2 on consecutive cycles after tag 0 completes.
- 16 allocs with no completion -> alloc_ready=0, and a 17th alloc_valid is ignored. Complete tag 0 -> one commit, then the next alloc returns tag 0 (wrap).
- Lookup index=5 while cdb2 broadcasts tag 5 data=77 in the same cycle -> ready=1, value=77. index=INVALID_TAG -> ready=0.
- cdb1 and cdb2 both tag=4 with data 10/20 -> entry 4 data=10. cdb1 tag=9 with entry 9 free -> no state change.
- 5 entries busy, flush=1 together with alloc_valid and cdb1 -> empty=1 and alloc_tag=0 next cycle, no commit. Async reset low mid-commit -> commit_valid drops to 0 immediately.
